// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, stall/flush,
// data-memory wait FSM with timeout, and saturating stall counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoRegE,
  input  logic             memtoRegM,
  input  logic             memWriteM,
  input  logic             branchD,
  input  logic             dmem_ready,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_ERR
  } state_t;

  state_t        state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          err_n;
  logic          mem_acc;
  logic          mem_stall;
  logic          lwstall;
  logic          branchstall;

  assign mem_acc = memtoRegM | memWriteM;

  assign lwstall = memtoRegE &
                   ((rtE == rsD) | (rtE == rtD));

  assign branchstall = branchD &
    ((regwriteE &
      ((writeregE == rsD) | (writeregE == rtD))) |
     (memtoRegM &
      ((writeregM == rsD) | (writeregM == rtD))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      mem_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    err_n   = mem_err;
    unique case (state)
      S_RUN: begin
        if (mem_acc && !dmem_ready) begin
          state_n = S_WAIT;
          wcnt_n  = WW'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_n = S_RUN;
        end else if (wcnt == WW'(MEM_TIMEOUT)) begin
          state_n = S_ERR;
          err_n   = 1'b1;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      S_ERR:   state_n = S_ERR;
      default: state_n = S_RUN;
    endcase
  end

  // Wait and error states freeze the whole pipe regardless of dmem_ready.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      S_RUN:   mem_stall = mem_acc & ~dmem_ready;
      S_WAIT:  mem_stall = 1'b1;
      S_ERR:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    if (!rst) begin
      if (rsE != 5'd0 && rsE == writeregM && regwriteM)
        forwardAE = 2'b10;
      else if (rsE != 5'd0 && rsE == writeregW && regwriteW)
        forwardAE = 2'b01;
      if (rtE != 5'd0 && rtE == writeregM && regwriteM)
        forwardBE = 2'b10;
      else if (rtE != 5'd0 && rtE == writeregW && regwriteW)
        forwardBE = 2'b01;
      forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
      forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
      stallF    = lwstall | branchstall | mem_stall;
      stallD    = lwstall | branchstall | mem_stall;
      stallE    = mem_stall;
      stallM    = mem_stall;
      flushW    = mem_stall;
      flushE    = (lwstall | branchstall) & ~mem_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (stallD && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (mem_stall && memwait_cnt != '1)
        memwait_cnt <= memwait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected output vectors are queued
// when inputs are driven and compared on the falling edge.
module tb_hazard_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rsD, rtD, rsE, rtE;
  logic [4:0]    writeregE, writeregM, writeregW;
  logic          regwriteE, regwriteM, regwriteW;
  logic          memtoRegE, memtoRegM, memWriteM;
  logic          branchD, dmem_ready;
  logic [1:0]    forwardAE, forwardBE;
  logic          forwardAD, forwardBD;
  logic          stallF, stallD, stallE, stallM;
  logic          flushE, flushW, mem_err;
  logic [CW-1:0] stall_cnt, memwait_cnt;

  int errors = 0;
  int checks = 0;

  logic [12:0] expq[$];
  string       tagq[$];
  logic [12:0] obs;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM),
    .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW),
    .memtoRegE(memtoRegE), .memtoRegM(memtoRegM),
    .memWriteM(memWriteM), .branchD(branchD),
    .dmem_ready(dmem_ready),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW),
    .mem_err(mem_err),
    .stall_cnt(stall_cnt), .memwait_cnt(memwait_cnt)
  );

  assign obs = {forwardAE, forwardBE, forwardAD, forwardBD,
                stallF, stallD, stallE, stallM,
                flushE, flushW, mem_err};

  function automatic logic [12:0] ov(
    input logic [1:0] fae, input logic [1:0] fbe,
    input logic fad, input logic fbd,
    input logic sf, input logic sd,
    input logic se, input logic sm,
    input logic fe, input logic fw, input logic me);
    return {fae, fbe, fad, fbd, sf, sd, se, sm, fe, fw, me};
  endfunction

  task automatic clr();
    rst = 1'b0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoRegE = 0; memtoRegM = 0; memWriteM = 0;
    branchD = 0; dmem_ready = 1'b1;
  endtask

  // Queue expectation for current inputs, compare mid-cycle, then
  // advance to just after the next rising edge.
  task automatic chk(input string tag, input logic [12:0] e);
    logic [12:0] x;
    string t;
    expq.push_back(e);
    tagq.push_back(tag);
    @(negedge clk);
    x = expq.pop_front();
    t = tagq.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chkc(input string tag,
                      input logic [CW-1:0] o,
                      input logic [CW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  localparam logic [12:0] Z = '0;

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // reset with active-looking inputs: outputs forced low
    rst = 1'b1;
    rsE = 1; writeregM = 1; regwriteM = 1;
    memtoRegM = 1; dmem_ready = 0;
    memtoRegE = 1; rtE = 1; rsD = 1;
    chk("reset_outs", Z);
    chkc("reset_stall_cnt", stall_cnt, 0);
    chkc("reset_memwait_cnt", memwait_cnt, 0);

    clr();
    chk("idle", Z);

    clr(); rsE = 1; rtE = 3; writeregM = 1; regwriteM = 1;
    chk("fwdAE_M", ov(2'b10,0,0,0,0,0,0,0,0,0,0));

    clr(); rsE = 1; writeregW = 1; regwriteW = 1;
    writeregM = 5; regwriteM = 1;
    chk("fwdAE_W", ov(2'b01,0,0,0,0,0,0,0,0,0,0));

    clr(); rsE = 1; writeregM = 1; regwriteM = 1;
    writeregW = 1; regwriteW = 1;
    chk("fwdAE_Mprio", ov(2'b10,0,0,0,0,0,0,0,0,0,0));

    clr(); rsE = 0; writeregM = 0; regwriteM = 1;
    writeregW = 0; regwriteW = 1;
    chk("fwd_reg0", Z);

    clr(); rtE = 7; writeregW = 7; regwriteW = 1;
    chk("fwdBE_W", ov(0,2'b01,0,0,0,0,0,0,0,0,0));

    clr(); rsE = 1; writeregM = 1; regwriteM = 0;
    chk("fwd_nowrite", Z);

    clr(); rsD = 2; rtD = 3; writeregM = 2; regwriteM = 1;
    chk("fwdAD", ov(0,0,1,0,0,0,0,0,0,0,0));

    clr(); memtoRegE = 1; rtE = 1; rtD = 1; rsD = 4;
    chk("lwstall", ov(0,0,0,0,1,1,0,0,1,0,0));
    chkc("stall_cnt_lw", stall_cnt, 1);

    clr();
    chk("after_lw", Z);
    chkc("stall_cnt_hold", stall_cnt, 1);

    clr(); branchD = 1; rsD = 1; regwriteE = 1; writeregE = 1;
    chk("branchstall_E", ov(0,0,0,0,1,1,0,0,1,0,0));

    clr(); branchD = 1; rsD = 1; writeregM = 1; regwriteM = 1;
    chk("branch_fwdAD", ov(0,0,1,0,0,0,0,0,0,0,0));

    clr(); branchD = 1; rtD = 6; memtoRegM = 1;
    writeregM = 6; regwriteM = 1;
    chk("branchstall_M", ov(0,0,0,1,1,1,0,0,1,0,0));
    chkc("stall_cnt_br", stall_cnt, 3);

    // load waits two cycles, completes on third
    clr(); memtoRegM = 1; writeregM = 9; regwriteM = 1;
    dmem_ready = 0;
    chk("memwait_1", ov(0,0,0,0,1,1,1,1,0,1,0));
    memtoRegE = 1; rtE = 2; rsD = 2;
    chk("memwait_2_lw", ov(0,0,0,0,1,1,1,1,0,1,0));
    memtoRegE = 0; rtE = 0; rsD = 0;
    dmem_ready = 1;
    chk("memwait_3_rdy", ov(0,0,0,0,1,1,1,1,0,1,0));
    clr();
    chk("memwait_done", Z);
    chkc("memwait_cnt_3", memwait_cnt, 3);
    chkc("stall_cnt_6", stall_cnt, 6);

    clr(); memWriteM = 1;
    chk("store_fast", Z);
    chkc("memwait_cnt_fast", memwait_cnt, 3);

    // timeout: RUN miss then four WAIT cycles, error on fifth
    clr(); memWriteM = 1; dmem_ready = 0;
    chk("to_run", ov(0,0,0,0,1,1,1,1,0,1,0));
    for (int i = 0; i < 4; i++)
      chk($sformatf("to_wait%0d", i),
          ov(0,0,0,0,1,1,1,1,0,1,0));
    clr(); dmem_ready = 1;
    chk("err_set", ov(0,0,0,0,1,1,1,1,0,1,1));
    memtoRegE = 1; rtE = 3; rtD = 3;
    chk("err_sticky", ov(0,0,0,0,1,1,1,1,0,1,1));
    chkc("memwait_cnt_10", memwait_cnt, 10);
    chkc("stall_cnt_13", stall_cnt, 13);
    clr();
    for (int i = 0; i < 8; i++)
      chk($sformatf("err_hold%0d", i),
          ov(0,0,0,0,1,1,1,1,0,1,1));
    chkc("stall_cnt_sat", stall_cnt, 15);
    chkc("memwait_cnt_sat", memwait_cnt, 15);

    clr(); rst = 1; rsE = 1; writeregM = 1; regwriteM = 1;
    chk("rst_in_err", ov(0,0,0,0,0,0,0,0,0,0,1));
    clr();
    chk("after_rst", Z);
    chkc("rst_stall_cnt", stall_cnt, 0);
    chkc("rst_memwait_cnt", memwait_cnt, 0);

    // reset while waiting must land back in RUN
    clr(); memWriteM = 1; dmem_ready = 0;
    chk("wait_enter", ov(0,0,0,0,1,1,1,1,0,1,0));
    rst = 1;
    chk("wait_rst", Z);
    clr();
    chk("wait_rst_run", Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
